ubin_acc_bi: RTL and testbench
==============================

// Module: ubin_acc_bi
// PURPOSE
//  Downstream stage of the bipolar stochastic multiplier: accumulates the product bitstream over a
//  fixed window of 2^WINLOG enabled cycles and converts it to a signed two's-complement value.
//  Sits between the SFFT uMUL_bi array and the binary butterfly/output logic.
//  Delivers each result through a valid/ready register and flags results lost to back-pressure.
// PARAMETERS
//  WINLOG    8   log2 of window length N = 2^WINLOG enabled samples (match multiplier BITWIDTH)
//  RES_W     WINLOG+2   result width (derived localparam, not overridable)
// PORTS
//  iClk     in   1        clock, all state on rising edge
//  iRst     in   1        asynchronous, active-high reset
//  iEn      in   1        sample enable; iEn=0 stalls the window (no sample, no count)
//  iClr     in   1        synchronous clear: abort window, drop pending result
//  iStart   in   1        start a window (honoured in IDLE only)
//  iCont    in   1        continuous mode: on window end, restart immediately without iStart
//  iBit     in   1        bipolar stochastic input bit (uMUL_bi oMult)
//  iReady   in   1        consumer accepts result when oValid & iReady
//  oBusy    out  1        1 while in RUN
//  oValid   out  1        result pending in oResult
//  oResult  out  RES_W    signed result = 2*ones - N, range -N..+N
//  oOvf     out  1        sticky: unconsumed result was overwritten
// BEHAVIOUR
//  - Reset (iRst=1, async): state IDLE, all counters 0; oBusy=0, oValid=0, oResult=0, oOvf=0.
//  - FSM IDLE/RUN. IDLE->RUN when iStart=1 (iClr=0); counters cleared on entry. iStart in RUN ignored.
//  - RUN, iEn=1: ones += iBit; smp += 1. iEn=0: hold everything.
//  - Window end = enabled cycle with smp == N-1. That sample is included. Next edge:
//    oResult <= {ones_final,1'b0} - N (RES_W-bit two's complement), oValid <= 1,
//    counters <= 0, state <= RUN if iCont=1 else IDLE. Latency: result visible 1 cycle after last sample.
//  - ones counter is WINLOG+1 bits (reaches N); smp counter WINLOG bits, wraps only at window end.
//  - Handshake: transfer on edge where oValid & iReady; oValid falls unless a new result lands same edge.
//  - New result while oValid=1 & iReady=0: overwrite oResult, oValid stays 1, oOvf <= 1.
//  - New result on same edge as transfer: new value loaded, oValid stays 1, oOvf unchanged.
//  - oResult stable while oValid=1 except for overwrite case.
//  - iClr=1: state IDLE, counters 0, oValid 0, oResult 0, oOvf 0; overrides iStart, window end, transfer.
//  - iRst mid-window: immediate abort; no partial result ever produced.
//  - iEn=0 does not block handshake; transfer still completes on iReady.
// STRUCTURE
//  - Shared package: IDLE/RUN state encoding, default WINLOG, RES_W derivation macro for all SFFT
//    converter stages.
//  - One sub-module: bi_win_cnt (smp + ones counters, enable/clear, last-sample strobe).
//  - Top: FSM, bipolar conversion subtractor, result/valid/overflow register.
// TESTING  (WINLOG=4, N=16)
//  1. Reset, iStart, iBit=1 for 16 enabled cycles -> oValid rises cycle 17, oResult=+16 (6'b010000).
//  2. iBit=0 x16 -> oResult=-16 (6'b110000); iBit=1010.. x16 -> oResult=0; oBusy low after each.
//  3. 16 enabled samples spread over 40 cycles (iEn gaps), 12 ones -> oResult=+8; gaps ignored.
//  4. iCont=1, iReady=0, two windows -> 2nd result overwrites, oOvf=1; repeat with iReady=1 on
//     2nd completion edge -> new value loaded, oValid stays 1, oOvf=0.
//  5. iRst pulse at sample 7 -> all outputs 0 at once; iStart after release -> fresh 16-sample window.
//  6. iClr with iStart same cycle mid-window and oValid=1 -> IDLE, oValid=0, oResult=0, no restart.

Source files
------------

// File: rtl/ubin_acc_bi_pkg.sv
// Shared definitions for the SFFT stochastic-to-binary converter stages.
// Holds the window FSM encoding, the default window size and the result width rule.
package ubin_acc_bi_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } accState_t;

    localparam int WINLOG_DEF = 8;

    // A window of 2^w samples gives a signed result in -N..+N, which needs w+2 bits.
    function automatic int resWidth(input int w);
        return w + 2;
    endfunction

endpackage

// File: rtl/ubin_acc_bi_win_cnt.sv
// Window counters for the bipolar accumulator.
// Counts enabled samples and ones; strobes on the last sample of a window.
module bi_win_cnt
    import ubin_acc_bi_pkg::*;
#(
    parameter int WINLOG = WINLOG_DEF
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iClr,
    input  logic              iEn,
    input  logic              iBit,
    output logic              oLast,
    output logic [WINLOG:0]   oOnesFinal
);

    localparam logic [WINLOG-1:0] SMP_LAST = '1;

    logic [WINLOG-1:0] smp;
    logic [WINLOG:0]   ones;

    assign oLast      = iEn && (smp == SMP_LAST);
    // Includes the sample being taken this cycle, so the window's final count is ready on the strobe.
    assign oOnesFinal = ones + {{WINLOG{1'b0}}, iBit};

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            smp  <= '0;
            ones <= '0;
        end else if (iClr || oLast) begin
            smp  <= '0;
            ones <= '0;
        end else if (iEn) begin
            smp  <= smp + 1'b1;
            ones <= oOnesFinal;
        end
    end

endmodule

// File: rtl/ubin_acc_bi.sv
// Bipolar stochastic accumulator: counts ones over 2^WINLOG samples and emits 2*ones-N.
// Results leave through a valid/ready register with a sticky overwrite flag.
module ubin_acc_bi
    import ubin_acc_bi_pkg::*;
#(
    parameter int WINLOG = WINLOG_DEF
) (
    input  logic                            iClk,
    input  logic                            iRst,
    input  logic                            iEn,
    input  logic                            iClr,
    input  logic                            iStart,
    input  logic                            iCont,
    input  logic                            iBit,
    input  logic                            iReady,
    output logic                            oBusy,
    output logic                            oValid,
    output logic [resWidth(WINLOG)-1:0]     oResult,
    output logic                            oOvf
);

    localparam int RES_W = resWidth(WINLOG);
    localparam logic [RES_W-1:0] N_RES = RES_W'(1) << WINLOG;

    accState_t state;
    accState_t stateNext;

    logic            cntEn;
    logic            cntClr;
    logic            last;
    logic            winEnd;
    logic [WINLOG:0] onesFinal;
    logic [RES_W-1:0] resNew;

    assign cntEn  = (state == RUN) && iEn;
    assign cntClr = iClr || ((state == IDLE) && iStart);
    assign winEnd = last && !iClr;
    assign resNew = {onesFinal, 1'b0} - N_RES;
    assign oBusy  = (state == RUN);

    bi_win_cnt #(
        .WINLOG(WINLOG)
    ) uWinCnt (
        .iClk      (iClk),
        .iRst      (iRst),
        .iClr      (cntClr),
        .iEn       (cntEn),
        .iBit      (iBit),
        .oLast     (last),
        .oOnesFinal(onesFinal)
    );

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        if (iClr) begin
            stateNext = IDLE;
        end else begin
            unique case (state)
                IDLE: if (iStart) stateNext = RUN;
                RUN:  if (winEnd) stateNext = iCont ? RUN : IDLE;
                default: stateNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oValid  <= 1'b0;
            oResult <= '0;
            oOvf    <= 1'b0;
        end else if (iClr) begin
            oValid  <= 1'b0;
            oResult <= '0;
            oOvf    <= 1'b0;
        end else if (winEnd) begin
            oResult <= resNew;
            oValid  <= 1'b1;
            // Only a result that nobody took this edge counts as lost.
            if (oValid && !iReady) begin
                oOvf <= 1'b1;
            end
        end else if (oValid && iReady) begin
            oValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ubin_acc_bi.sv
// Self-checking bench for ubin_acc_bi with WINLOG=4.
// Reference model keeps the window as a queue of sample bits.
module tb_ubin_acc_bi;

    localparam int WL = 4;
    localparam int N  = 16;
    localparam int RW = 6;

    logic iClk = 1'b0;
    logic iRst, iEn, iClr, iStart, iCont, iBit, iReady;
    logic oBusy, oValid, oOvf;
    logic [RW-1:0] oResult;

    int total = 0;
    int bad   = 0;

    bit mBusy, mValid, mOvf;
    int mRes;
    int q[$];

    always #5 iClk = ~iClk;

    ubin_acc_bi #(.WINLOG(WL)) dut (
        .iClk   (iClk),
        .iRst   (iRst),
        .iEn    (iEn),
        .iClr   (iClr),
        .iStart (iStart),
        .iCont  (iCont),
        .iBit   (iBit),
        .iReady (iReady),
        .oBusy  (oBusy),
        .oValid (oValid),
        .oResult(oResult),
        .oOvf   (oOvf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        mBusy = 0; mValid = 0; mOvf = 0; mRes = 0;
        q.delete();
    endtask

    task automatic modelEdge();
        bit newRes;
        int r;
        int sum;
        newRes = 0;
        r = 0;
        if (iClr) begin
            modelReset();
            return;
        end
        if (mBusy && iEn) begin
            q.push_back(int'(iBit));
            if (q.size() == N) begin
                sum = 0;
                foreach (q[i]) sum += q[i];
                r = 2 * sum - N;
                newRes = 1;
                q.delete();
                mBusy = iCont;
            end
        end else if (!mBusy && iStart) begin
            mBusy = 1;
            q.delete();
        end
        if (newRes) begin
            if (mValid && !iReady) mOvf = 1;
            mRes = r;
            mValid = 1;
        end else if (mValid && iReady) begin
            mValid = 0;
        end
    endtask

    task automatic checkAll(input string tag);
        logic [RW-1:0] e;
        e = mRes[RW-1:0];
        check({tag, ".busy"}, 32'(oBusy), 32'(mBusy));
        check({tag, ".valid"}, 32'(oValid), 32'(mValid));
        check({tag, ".ovf"}, 32'(oOvf), 32'(mOvf));
        check({tag, ".res"}, 32'(oResult), 32'(e));
    endtask

    task automatic cyc(input logic en, input logic st, input logic b,
                       input logic rdy, input logic cont, input logic clr,
                       input string tag);
        iEn = en; iStart = st; iBit = b; iReady = rdy; iCont = cont; iClr = clr;
        @(posedge iClk);
        modelEdge();
        #1;
        checkAll(tag);
    endtask

    task automatic midReset(input string tag);
        #2 iRst = 1'b1;
        #1;
        modelReset();
        checkAll({tag, ".async"});
        @(posedge iClk);
        #1;
        checkAll({tag, ".hold"});
        iRst = 1'b0;
    endtask

    initial begin
        iRst = 1'b1;
        iEn = 0; iClr = 0; iStart = 0; iCont = 0; iBit = 0; iReady = 0;
        modelReset();
        #1;
        checkAll("rst0");
        @(posedge iClk);
        #1;
        checkAll("rst1");
        iRst = 1'b0;

        // all ones -> +16, valid appears the cycle after sample 16
        cyc(0, 1, 0, 0, 0, 0, "t1s");
        for (int i = 0; i < N; i++) cyc(1, 0, 1, 0, 0, 0, "t1");
        check("t1.val", 32'(oValid), 32'd1);
        check("t1.res", 32'(oResult), 32'h10);
        check("t1.busy", 32'(oBusy), 32'd0);

        // all zeros -> -16
        cyc(0, 1, 0, 1, 0, 0, "t2s");
        for (int i = 0; i < N; i++) cyc(1, 0, 0, 0, 0, 0, "t2a");
        check("t2a.res", 32'(oResult), 32'h30);
        check("t2a.busy", 32'(oBusy), 32'd0);

        // alternating -> 0
        cyc(0, 1, 0, 1, 0, 0, "t2s2");
        for (int i = 0; i < N; i++) cyc(1, 0, i % 2 == 0, 0, 0, 0, "t2b");
        check("t2b.res", 32'(oResult), 32'h00);
        check("t2b.val", 32'(oValid), 32'd1);

        // 16 samples over 40 cycles, 12 ones, gap bits are 0-and-1 noise
        cyc(0, 1, 0, 1, 0, 0, "t3s");
        begin
            int n;
            n = 0;
            for (int c = 0; c < 40; c++) begin
                if (c % 5 == 1 || c % 5 == 3 || n >= N || (c > 30 && n < 9)) begin
                    cyc(0, 0, c[0], 0, 0, 0, "t3g");
                end else begin
                    cyc(1, 0, n < 12, 0, 0, 0, "t3");
                    n++;
                end
            end
            while (n < N) begin
                cyc(1, 0, n < 12, 0, 0, 0, "t3x");
                n++;
            end
        end
        check("t3.res", 32'(oResult), 32'h08);

        // continuous mode, no consumer -> overwrite
        cyc(0, 0, 0, 0, 0, 1, "t4c");
        cyc(0, 1, 0, 0, 1, 0, "t4s");
        for (int i = 0; i < N; i++) cyc(1, 0, 1, 0, 1, 0, "t4a");
        for (int i = 0; i < N; i++) cyc(1, 0, i < 4, 0, i != N - 1, 0, "t4b");
        check("t4.ovf", 32'(oOvf), 32'd1);
        check("t4.res", 32'(oResult), 32'h38);

        // consumer takes the first result on the edge the second lands
        cyc(0, 0, 0, 0, 0, 1, "t4c2");
        cyc(0, 1, 0, 0, 1, 0, "t4s2");
        for (int i = 0; i < N; i++) cyc(1, 0, 0, 0, 1, 0, "t4d");
        for (int i = 0; i < N; i++) cyc(1, 0, 1, i == N - 1, i != N - 1, 0, "t4e");
        check("t4e.val", 32'(oValid), 32'd1);
        check("t4e.ovf", 32'(oOvf), 32'd0);
        check("t4e.res", 32'(oResult), 32'h10);

        // async reset at sample 7 then fresh window
        cyc(0, 1, 0, 1, 0, 0, "t5s");
        for (int i = 0; i < 7; i++) cyc(1, 0, 0, 0, 0, 0, "t5a");
        midReset("t5r");
        cyc(0, 1, 0, 0, 0, 0, "t5s2");
        for (int i = 0; i < N; i++) cyc(1, 0, 1, 0, 0, 0, "t5b");
        check("t5.res", 32'(oResult), 32'h10);

        // clear with start mid-window while a result is pending
        cyc(0, 1, 0, 0, 1, 0, "t6s");
        for (int i = 0; i < N + 5; i++) cyc(1, 0, 1, 0, 1, 0, "t6a");
        cyc(1, 1, 1, 0, 1, 1, "t6c");
        check("t6.busy", 32'(oBusy), 32'd0);
        check("t6.val", 32'(oValid), 32'd0);
        check("t6.res", 32'(oResult), 32'd0);
        cyc(1, 0, 1, 0, 1, 0, "t6i");

        // randomized traffic
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 699) == 0) begin
                midReset("rr");
            end else begin
                cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                    1'($urandom), $urandom_range(0, 2) == 0,
                    $urandom_range(0, 2) != 0, $urandom_range(0, 149) == 0, "rnd");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
